mixcol_sequencer: RTL and testbench
===================================

# mixcol_sequencer

Iterative MixColumns engine for the AES round datapath. It accepts one 128-bit state block over a valid/ready handshake and pushes its four 32-bit columns, one per cycle, through a single shared combinational column mixer. It returns the mixed block over a second valid/ready handshake. It sits between the ShiftRows stage and AddRoundKey, and it trades a 4-cycle latency for one column mixer instead of four.

## Interface
- `clk`  input  1  rising-edge clock
- `rst`  input  1  asynchronous, active-high reset
- `in_valid`  input  1  upstream block valid
- `in_ready`  output  1  block accepted on an edge where `in_valid & in_ready`
- `in_data`  input  128  state block; column c = `in_data[127-32c -: 32]`, row-0 byte in the column's top byte
- `in_bypass`  input  1  sampled with the block; pass the block through unmixed (final AES round)
- `in_inv`  input  1  sampled with the block; apply InvMixColumns (port exists only with `MIXCOL_INV_EN`)
- `out_valid`  output  1  result block valid
- `out_ready`  input  1  downstream accepts
- `out_data`  output  128  result block, same column layout as `in_data`
- `busy`  output  1  high in the COL state

## Operation
- FSM states:
  - IDLE: `in_ready=1`. On accept, load `in_data` into the 128-bit buffer, latch the mode bits, clear the column counter, and go to COL. If `in_bypass`=1, go to DONE instead with the buffer holding `in_data` unchanged.
  - COL: each cycle, take buffer column `cnt` (2-bit), pass it through the mixer, write the result back into the same column, and increment `cnt`. After writing column 3, go to DONE. `in_ready=0`.
  - DONE: `out_valid=1`, `out_data` = buffer, held stable until `out_ready`. `in_ready = out_ready` (combinational path).
    - Handshake with no new input → IDLE.
    - Handshake together with an input accept on the same edge → reload the buffer and go to COL, or to DONE if bypass.
- Mixer:
  - `{s0,s1,s2,s3}` → `{2s0^3s1^s2^s3, s0^2s1^3s2^s3, s0^s1^2s2^3s3, 3s0^s1^s2^2s3}`.
  - xtime reduction polynomial 0x11B.
  - All arithmetic is GF(2^8) XOR; there are no carries.
- `in_bypass` and `in_inv` are ignored when not accepted. Once latched, they are stable for the whole block.
- `out_valid` is never withdrawn without a handshake. `out_data` does not change while `out_valid=1 & !out_ready`.

## Timing
- Reset (asynchronous):
  - state=IDLE, `cnt`=0, buffer=0, mode bits=0.
  - `in_ready`=1, `out_valid`=0, `out_data`=0, `busy`=0.
- Reset mid-block discards the block. No partial output is ever presented.
- Latency, counted from the accept edge E0:
  - Columns are written at E1–E4.
  - `out_valid` rises after E4 (4 cycles).
  - With bypass, `out_valid` rises after E0 (1 cycle).
- Throughput with `out_ready` held high: one block per 5 cycles, or one per 1 cycle with bypass. There is no idle bubble between back-to-back blocks.
- `out_valid & !out_ready` stalls indefinitely. The buffer and `cnt` are frozen while stalled.

## Configuration
- `MIXCOL_INV_EN` defined:
  - The `in_inv` port exists.
  - When the latched `in_inv`=1, each column is first pre-conditioned: u = 4·(s0^s2), v = 4·(s1^s3); s0^=u, s1^=v, s2^=u, s3^=v. It is then passed through the same forward mixer. The result is InvMixColumns.
  - Latency and cycle counts are unchanged.
- `MIXCOL_INV_EN` undefined:
  - No `in_inv` port and no pre-conditioning logic.
  - Forward MixColumns only.

## Structure
- Shared package `aes_pkg`:
  - `AES_STATE_W`=128, `AES_COL_W`=32, `AES_POLY`=8'h1B.
  - A `col_t` type (4×8-bit) and an `xtime` function.
  - The FSM state enum `mixcol_state_t` (IDLE, COL, DONE).
- One sub-module, `mix_column`: a purely combinational 32-bit column mixer. It also contains the inverse pre-conditioner, under the macro. The sequencer owns the buffer, counter, FSM and handshakes.

## Test plan
- Single column: block with column 0 = `db135345`, others `01010101` → column 0 = `8e4da1bc`, others `01010101`. `out_valid` rises 4 cycles after accept.
- FIPS-197 round-1 vector: `d4bf5d30e0b452aeb84111f11e2798e5` → `046681e5e0cb199a48f8d37a2806264c`.
- Bypass: `in_bypass`=1 with the vector above → same data out, `out_valid` 1 cycle after accept.
- Backpressure and back-to-back:
  - Hold `out_ready`=0 for 10 cycles → `out_data` stable and `in_ready`=0 throughout.
  - Then `out_ready`=1 with `in_valid`=1 carrying `c6c6c6c6f20a225cd4d4d4d501010101` → accepted on the same edge, result `c6c6c6c69fdc589dd5d5d7d601010101`.
- Reset at E2 of a block → all outputs return to reset values immediately and `out_valid` never asserts for that block. The next block completes correctly.
- With `MIXCOL_INV_EN`: `in_inv`=1 on `046681e5e0cb199a48f8d37a2806264c` → `d4bf5d30e0b452aeb84111f11e2798e5`, latency 4.

Source files
------------

// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared AES datapath definitions for the round pipeline.
//   AES_STATE_W / AES_COL_W : 128-bit state, 32-bit column
//   AES_POLY                : low byte of the GF(2^8) reduction polynomial 0x11B
//   col_t                   : one column, element 0 = row-0 byte (top byte)
//   mixcol_state_t          : sequencer FSM states
//   xtime()                 : multiply a byte by {02} in GF(2^8)
// -----------------------------------------------------------------------------
package aes_pkg;

    localparam int         AES_STATE_W = 128;
    localparam int         AES_COL_W   = 32;
    localparam logic [7:0] AES_POLY    = 8'h1B;

    // Ascending element range so col[0] lands in the most significant byte,
    // matching the row-0-on-top column layout of the state block.
    typedef logic [0:3][7:0] col_t;

    typedef enum logic [1:0] {
        IDLE,
        COL,
        DONE
    } mixcol_state_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/mix_column.sv
// -----------------------------------------------------------------------------
// mix_column
// Purely combinational AES MixColumns for one 32-bit column.
// With MIXCOL_INV_EN defined, an extra `inv` input selects InvMixColumns,
// built as a cheap pre-conditioning step followed by the forward mixer.
//   inv     : (MIXCOL_INV_EN only) apply the inverse transform
//   col_in  : input column, col_in[0] = row-0 byte
//   col_out : mixed column, same layout
// -----------------------------------------------------------------------------
module mix_column
    import aes_pkg::*;
(
`ifdef MIXCOL_INV_EN
    input  logic inv,
`endif
    input  col_t col_in,
    output col_t col_out
);

    col_t s;   // column fed to the forward mixer
    col_t x;   // {02}·s per byte

`ifdef MIXCOL_INV_EN
    logic [7:0] u;
    logic [7:0] v;

    // InvMixColumns = MixColumns · P where P adds {04}·(s0^s2) to the even
    // rows and {04}·(s1^s3) to the odd rows.
    assign u = xtime(xtime(col_in[0] ^ col_in[2]));
    assign v = xtime(xtime(col_in[1] ^ col_in[3]));
    assign s = inv ? {col_in[0] ^ u, col_in[1] ^ v, col_in[2] ^ u, col_in[3] ^ v}
                   : col_in;
`else
    assign s = col_in;
`endif

    assign x = {xtime(s[0]), xtime(s[1]), xtime(s[2]), xtime(s[3])};

    // {03}·a is written as x[a] ^ s[a].
    assign col_out[0] = x[0] ^ x[1] ^ s[1] ^ s[2] ^ s[3];
    assign col_out[1] = s[0] ^ x[1] ^ x[2] ^ s[2] ^ s[3];
    assign col_out[2] = s[0] ^ s[1] ^ x[2] ^ x[3] ^ s[3];
    assign col_out[3] = x[0] ^ s[0] ^ s[1] ^ s[2] ^ x[3];

endmodule

// File: rtl/mixcol_sequencer.sv
// -----------------------------------------------------------------------------
// mixcol_sequencer
// Iterative MixColumns engine: accepts a 128-bit state block, mixes its four
// columns one per cycle through a single shared mix_column, and returns the
// block. Optional feature macro: MIXCOL_INV_EN (adds in_inv / InvMixColumns).
//   clk, rst             : rising-edge clock, async active-high reset
//   in_valid/in_ready    : input handshake, in_data = state block
//   in_bypass            : pass the block through unmixed (final round)
//   in_inv               : (MIXCOL_INV_EN only) InvMixColumns for this block
//   out_valid/out_ready  : output handshake, out_data = result block
//   busy                 : columns are being mixed
// -----------------------------------------------------------------------------
module mixcol_sequencer
    import aes_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_STATE_W-1:0] in_data,
    input  logic                   in_bypass,
`ifdef MIXCOL_INV_EN
    input  logic                   in_inv,
`endif
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_STATE_W-1:0] out_data,
    output logic                   busy
);

    mixcol_state_t          state;
    mixcol_state_t          state_next;
    logic [AES_STATE_W-1:0] blk;
    logic [1:0]             cnt;
    logic                   accept;
    col_t                   col_cur;
    col_t                   col_mix;
`ifdef MIXCOL_INV_EN
    logic                   inv_q;
`endif

    assign accept   = in_valid & in_ready;
    assign col_cur  = blk[AES_STATE_W-1 - AES_COL_W*cnt -: AES_COL_W];
    assign out_data = blk;

    mix_column u_mix (
`ifdef MIXCOL_INV_EN
        .inv     (inv_q),
`endif
        .col_in  (col_cur),
        .col_out (col_mix)
    );

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic. In DONE an accept can only happen together with the
    // output handshake because in_ready follows out_ready there.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_next
        // unassigned and a latch is never inferred.
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = in_bypass ? DONE : COL;
            COL:  if (cnt == 2'd3) state_next = DONE;
            DONE: if (out_ready) state_next = accept ? (in_bypass ? DONE : COL) : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: in_ready = 1'b1;
            COL:  busy     = 1'b1;
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
            end
            default: ;
        endcase
    end

    // Block buffer, column counter and latched mode. Everything holds while
    // DONE is stalled, which keeps out_data stable until the handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the buffer is reset on purpose: it drives out_data
            // directly and must read zero after reset.
            blk <= '0;
            cnt <= '0;
`ifdef MIXCOL_INV_EN
            inv_q <= 1'b0;
`endif
        end else if (accept) begin
            blk <= in_data;
            cnt <= '0;
`ifdef MIXCOL_INV_EN
            inv_q <= in_inv;
`endif
        end else if (state == COL) begin
            blk[AES_STATE_W-1 - AES_COL_W*cnt -: AES_COL_W] <= col_mix;
            cnt <= cnt + 2'd1;
        end
    end

endmodule

// File: tb/tb_mixcol_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mixcol_sequencer
// Self-checking bench for mixcol_sequencer. Expected blocks come from a
// GF(2^8) matrix-multiply model of (Inv)MixColumns; directed vectors cover
// the known-answer cases, handshakes, stalls, bypass and mid-block reset,
// followed by randomized blocks with random output stalls.
// Define MIXCOL_INV_EN to build and exercise the inverse path.
// -----------------------------------------------------------------------------
module tb_mixcol_sequencer;

`ifdef MIXCOL_INV_EN
    localparam bit INV_EN = 1'b1;
`else
    localparam bit INV_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         in_bypass;
    logic         in_inv;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mixcol_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_bypass (in_bypass),
`ifdef MIXCOL_INV_EN
        .in_inv    (in_inv),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b);
        logic [7:0] a = a_in;
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= a;
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1B) : {a[6:0], 1'b0};
        end
        return p;
    endfunction

    // out[r] = sum_j M[r][j]·in[j], M circulant with first row fwd or inv_row.
    function automatic logic [127:0] ref_mix(input logic [127:0] d, input bit byp, input bit inv);
        logic [7:0]   fwd[4]     = '{8'h02, 8'h03, 8'h01, 8'h01};
        logic [7:0]   inv_row[4] = '{8'h0E, 8'h0B, 8'h0D, 8'h09};
        logic [127:0] r = '0;
        logic [7:0]   acc;
        logic [7:0]   coef;
        if (byp) return d;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++) begin
                    coef = inv ? inv_row[(j - row) & 3] : fwd[(j - row) & 3];
                    acc ^= gmul(d[127 - 32*c - 8*j -: 8], coef);
                end
                r[127 - 32*c - 8*row -: 8] = acc;
            end
        end
        return r;
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at the negedge right after the accept edge E0. Waits for
    // out_valid and checks the edge index at which it rose plus the data.
    task automatic wait_result(input string tag, input int exp_edge, input logic [127:0] exp_data);
        int k = 0;
        while (!out_valid && k < 20) begin
            check({tag, " busy"}, busy, 1'b1);
            check({tag, " in_ready low"}, in_ready, 1'b0);
            @(posedge clk);
            @(negedge clk);
            k++;
        end
        check({tag, " latency"}, k, exp_edge);
        check({tag, " data"}, out_data, exp_data);
    endtask

    task automatic send_block(input string tag, input logic [127:0] d, input bit byp,
                              input bit inv, input int exp_edge);
        @(negedge clk);
        check({tag, " in_ready idle"}, in_ready, 1'b1);
        in_valid  = 1'b1;
        in_data   = d;
        in_bypass = byp;
        in_inv    = inv;
        @(posedge clk);
        @(negedge clk);
        // Garbage on the mode/data inputs must be ignored once accepted.
        in_valid  = 1'b0;
        in_data   = {$urandom, $urandom, $urandom, $urandom};
        in_bypass = 1'($urandom);
        in_inv    = INV_EN & 1'($urandom);
        wait_result(tag, exp_edge, ref_mix(d, byp, inv));
    endtask

    // Stall for `stall` cycles with the result held, then take it.
    task automatic drain(input string tag, input int stall);
        logic [127:0] held = out_data;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            @(negedge clk);
            check({tag, " stall hold"}, {out_valid, out_data}, {1'b1, held});
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, " out_valid drop"}, out_valid, 1'b0);
    endtask

    localparam logic [127:0] FIPS_IN  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [127:0] FIPS_OUT = 128'h046681e5e0cb199a48f8d37a2806264c;
    localparam logic [127:0] C6_IN    = 128'hc6c6c6c6f20a225cd4d4d4d501010101;
    localparam logic [127:0] C6_OUT   = 128'hc6c6c6c69fdc589dd5d5d7d601010101;

    initial begin
        logic [127:0] d;
        logic [127:0] bb[5];
        bit           byp;
        bit           inv;
        bit           seen;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_bypass = 1'b0;
        in_inv    = 1'b0;
        out_ready = 1'b0;
        #1;
        check("reset outputs", {in_ready, out_valid, busy, out_data},
              {1'b1, 1'b0, 1'b0, 128'h0});
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Single column.
        d = {32'hdb135345, 32'h01010101, 32'h01010101, 32'h01010101};
        send_block("col0", d, 1'b0, 1'b0, 4);
        check("col0 known", out_data,
              {32'h8e4da1bc, 32'h01010101, 32'h01010101, 32'h01010101});
        drain("col0", 0);

        // FIPS-197 round-1 vector.
        send_block("fips", FIPS_IN, 1'b0, 1'b0, 4);
        check("fips known", out_data, FIPS_OUT);
        drain("fips", 2);

        // Bypass.
        send_block("bypass", FIPS_IN, 1'b1, 1'b0, 0);
        check("bypass known", out_data, FIPS_IN);
        drain("bypass", 0);

        // Backpressure for 10 cycles, then handshake + accept on one edge.
        send_block("bp", FIPS_IN, 1'b0, 1'b0, 4);
        in_valid  = 1'b1;
        in_data   = C6_IN;
        in_bypass = 1'b0;
        in_inv    = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("bp stall", {out_valid, in_ready, out_data}, {1'b1, 1'b0, FIPS_OUT});
        end
        out_ready = 1'b1;
        #1;
        check("bp in_ready follows out_ready", in_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("bp reload no bubble", {out_valid, busy}, {1'b0, 1'b1});
        wait_result("bp c6", 4, C6_OUT);
        check("bp c6 known", out_data, C6_OUT);
        drain("bp c6", 0);

        // Back-to-back bypass blocks at one per cycle.
        for (int i = 0; i < 5; i++) bb[i] = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        in_valid  = 1'b1;
        in_bypass = 1'b1;
        in_data   = bb[0];
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("b2b bypass", {out_valid, out_data}, {1'b1, bb[i]});
            if (i < 4) in_data = bb[i + 1];
            else       in_valid = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        in_bypass = 1'b0;
        check("b2b idle", {out_valid, in_ready}, {1'b0, 1'b1});

        // Reset at E2 of a block.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = FIPS_IN;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("midreset outputs", {in_ready, out_valid, busy, out_data},
              {1'b1, 1'b0, 1'b0, 128'h0});
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen |= out_valid;
        end
        check("midreset no output", seen, 1'b0);
        send_block("after reset", FIPS_IN, 1'b0, 1'b0, 4);
        check("after reset known", out_data, FIPS_OUT);
        drain("after reset", 1);

        // Inverse known answer.
        if (INV_EN) begin
            send_block("inv", FIPS_OUT, 1'b0, 1'b1, 4);
            check("inv known", out_data, FIPS_IN);
            drain("inv", 0);
        end

        // Randomized blocks.
        for (int n = 0; n < 40; n++) begin
            d   = {$urandom, $urandom, $urandom, $urandom};
            byp = ($urandom_range(3) == 0);
            inv = INV_EN & 1'($urandom);
            send_block("rand", d, byp, inv, byp ? 0 : 4);
            drain("rand", int'($urandom_range(3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
